note_recorder: RTL and testbench
================================

Name: note_recorder

Overview:
- Parametrised successor to the single-channel key recorder.
- Time-stamps press and release edges on NUM_KEYS debounced key inputs and logs them into an internal event RAM. The log is written in RECORD mode and replayed as key waveforms in PLAY mode.
- Sits between the board key/switch logic and the tone generators. `play_keys` drives the tone enables, and `last_event` feeds the HEX displays.

Parameters:
- NUM_KEYS, 4, number of key channels (1..16).
- KEY_W, 2, width of the key index; must satisfy `2^KEY_W >= NUM_KEYS`.
- TICK_DIV, 500000, clock cycles per time tick (0.01 s at 50 MHz).
- TIME_W, 14, width of the timestamp in ticks.
- DEPTH, 1024, number of event RAM entries (power of two).
- ADDR_W, 10, equal to log2(DEPTH).

Ports:
- clock  in  1  system clock (CLOCK_50 at the top level).
- reset  in  1  synchronous, active-high.
- mode  in  2  operating mode: 01 = RECORD, 10 = PLAY, 11 = CLEAR, 00 = none. Sampled only on `start`.
- start  in  1  single-cycle pulse; begins the operation selected by `mode`.
- stop  in  1  single-cycle pulse; ends RECORD or PLAY.
- keys  in  NUM_KEYS  live keys, 1 = pressed, already debounced.
- play_keys  out  NUM_KEYS  replayed key levels.
- sys_time  out  TIME_W  current tick count.
- event_count  out  ADDR_W+1  number of valid logged events.
- last_event  out  KEY_W+1+TIME_W  most recently written or replayed event, packed as {key, edge, time}; edge = 1 means press.
- busy  out  1  high in REC, FETCH and WAIT.
- done  out  1  one-cycle pulse when RECORD or PLAY ends.
- overflow  out  1  sticky; set when an event was dropped.

Behaviour:
- Reset: every output is 0, FSM = IDLE, prescaler = TICK_DIV-1, all pending flags cleared. RAM contents are don't-care, since `event_count` = 0.
- Prescaler: runs only in REC, FETCH and WAIT.
  - Counts down; when it reaches 0 it reloads and emits `tick`.
  - `sys_time` increments on `tick` and saturates at 2^TIME_W-1.
  - Entering REC or PLAY clears `sys_time` and reloads the prescaler.
- FSM states are IDLE, REC, FETCH, WAIT.
- IDLE:
  - `start` with mode 01: go to REC; `event_count` and `overflow` are cleared.
  - `start` with mode 10 and `event_count` > 0: go to FETCH with rd_ptr = 0.
  - `start` with mode 10 and `event_count` = 0: `done` pulses next cycle; state stays IDLE.
  - `start` with mode 11: clear `event_count` and `overflow`; state stays IDLE.
  - `start` with mode 00: no effect.
- REC edge capture:
  - Each cycle, keys are compared with a registered copy per key.
  - An edge sets pending[k] and latches ts[k] = `sys_time` in the same cycle.
- REC edge logging:
  - One RAM write per cycle, taking the lowest-index pending key.
  - The write stores {k, edge, ts[k]} at address `event_count`, then increments `event_count` and updates `last_event`.
  - A new edge on a key that is already pending replaces that pending entry and sets `overflow`.
- RAM full: when `event_count` = DEPTH, further edges are dropped and `overflow` is set.
- REC exit: `stop`, or `sys_time` reaching saturation.
  - Pending entries are flushed first, one per cycle.
  - Then the FSM goes to IDLE and `done` pulses.
  - Keys still held produce no release event.
- FETCH: issue a RAM read at rd_ptr (1-cycle read latency), then go to WAIT.
- WAIT:
  - When `sys_time` >= the event time, set `play_keys[key]` to the edge value, update `last_event` and increment rd_ptr.
  - If rd_ptr then equals `event_count`, go to IDLE, clear `play_keys` and pulse `done`. Otherwise go back to FETCH.
  - Several events with the same timestamp are applied on consecutive cycles, at most 2 cycles apart each.
- `stop` in FETCH or WAIT: go to IDLE on the next cycle, clear `play_keys`, pulse `done`.
- Ignored inputs:
  - `start` is ignored while `busy`.
  - `stop` is ignored in IDLE.
  - If `start` and `stop` arrive in the same cycle in IDLE, `start` wins.
- Reset during any state: returns to the full reset values on the next edge.

Decomposition:
- Shared package `piano_pkg` holds:
  - the mode encodings,
  - the FSM state enum,
  - the event field offsets and the EV_W function (KEY_W+1+TIME_W),
  - the default TICK_DIV.
- One sub-module, `event_ram`: a single-port synchronous RAM (DEPTH x EV_W, registered read) so it infers block memory.

Test Plan:
All scenarios use TICK_DIV=4, TIME_W=8, DEPTH=8.
- Reset, then idle for 20 cycles -> `sys_time` = 0, `busy` = 0, `play_keys` = 0, `event_count` = 0.
- RECORD, press key 1 at tick 3, release it at tick 7, then `stop` -> `event_count` = 2; RAM holds {1,1,3} and {1,0,7}; `done` pulses once.
- Keys 0 and 2 pressed in the same cycle at tick 5 -> entries written in the order key 0 then key 2, both with time 5.
- After the previous recording, PLAY -> `play_keys[1]` rises at tick 3 and falls at tick 7; `done` pulses once; `play_keys` ends at 0.
- 9 edges recorded -> `event_count` = 8, `overflow` = 1, the 9th edge is absent from RAM.
- Record with no `stop` -> auto-stop at tick 255; `done` pulses once. A following PLAY with `stop` issued mid-run -> `play_keys` cleared the cycle after `stop`.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared types and event-word layout for the note recorder.
// An event word is packed as {key, edge, time} with time in the low bits.
package piano_pkg;

    typedef enum logic [1:0] {
        MODE_NONE   = 2'b00,
        MODE_RECORD = 2'b01,
        MODE_PLAY   = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REC,
        ST_FETCH,
        ST_WAIT
    } state_e;

    localparam int DEFAULT_TICK_DIV = 500000;
    localparam int EV_TIME_LSB      = 0;

    function automatic int ev_edge_bit(input int time_w);
        return time_w;
    endfunction

    function automatic int ev_key_lsb(input int time_w);
        return time_w + 1;
    endfunction

    function automatic int ev_w(input int key_w, input int time_w);
        return key_w + 1 + time_w;
    endfunction

endpackage

// File: rtl/event_ram.sv
// Single-port event log memory with a registered read port.
// Reads update rdata only on enabled non-write cycles, so the word stays put while the player waits.
module event_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int EV_W   = 17
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [EV_W-1:0]   wdata,
    output logic [EV_W-1:0]   rdata
);

    logic [EV_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/note_recorder.sv
// Multi-key press/release recorder: time-stamps key edges into an event RAM in RECORD
// mode and replays them as key levels in PLAY mode.
module note_recorder
    import piano_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int KEY_W    = 2,
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int TIME_W   = 14,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic                    start,
    input  logic                    stop,
    input  logic [NUM_KEYS-1:0]     keys,
    output logic [NUM_KEYS-1:0]     play_keys,
    output logic [TIME_W-1:0]       sys_time,
    output logic [ADDR_W:0]         event_count,
    output logic [KEY_W+TIME_W:0]   last_event,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int EV_W       = ev_w(KEY_W, TIME_W);
    localparam int EV_EDGE    = ev_edge_bit(TIME_W);
    localparam int EV_KEY_LSB = ev_key_lsb(TIME_W);
    localparam int PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_RELOAD = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE    = PRESC_W'(1);
    localparam logic [TIME_W-1:0]  TIME_ONE     = TIME_W'(1);
    localparam logic [ADDR_W:0]    CNT_ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]    CNT_FULL     = (ADDR_W+1)'(DEPTH);

    state_e                state;
    logic [PRESC_W-1:0]    presc;
    logic [NUM_KEYS-1:0]   keys_q;
    logic [NUM_KEYS-1:0]   pending;
    logic [NUM_KEYS-1:0]   pedge;
    logic [TIME_W-1:0]     ts [NUM_KEYS];
    logic                  stopping;
    logic [ADDR_W:0]       rd_ptr;

    logic                  wr_any;
    logic [KEY_W-1:0]      wr_idx;
    logic [NUM_KEYS-1:0]   wr_bit;
    logic [TIME_W-1:0]     wr_ts;
    logic                  wr_edge;
    logic                  wr_en;
    logic [EV_W-1:0]       wr_data;
    logic [NUM_KEYS-1:0]   edges;
    logic [NUM_KEYS-1:0]   capture;
    logic [NUM_KEYS-1:0]   pend_clr;
    logic                  full;
    logic                  sat;
    logic                  rec_exit;
    logic                  collide;
    logic                  drop_edge;
    logic                  ram_en;
    logic [ADDR_W-1:0]     ram_addr;
    logic [EV_W-1:0]       rd_data;
    logic [TIME_W-1:0]     ev_time;
    logic                  ev_edge;
    logic [KEY_W-1:0]      ev_key;
    logic [ADDR_W:0]       rd_ptr_inc;

    // Lowest-index pending key wins the single write slot each cycle.
    always_comb begin
        wr_any  = 1'b0;
        wr_idx  = '0;
        wr_bit  = '0;
        wr_ts   = '0;
        wr_edge = 1'b0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pending[k]) begin
                wr_any = 1'b1;
                wr_idx = KEY_W'(k);
            end
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (wr_any && (wr_idx == KEY_W'(k))) begin
                wr_bit[k] = 1'b1;
                wr_ts     = ts[k];
                wr_edge   = pedge[k];
            end
        end
    end

    always_comb begin
        full      = (event_count == CNT_FULL);
        sat       = (sys_time == '1);
        rec_exit  = stopping | stop | sat;
        wr_en     = (state == ST_REC) && wr_any && !full;
        wr_data   = {wr_idx, wr_edge, wr_ts};
        edges     = keys ^ keys_q;
        capture   = ((state == ST_REC) && !rec_exit && !full) ? edges : '0;
        drop_edge = (state == ST_REC) && !rec_exit && full && (|edges);
        pend_clr  = pending & ~wr_bit;
        collide   = |(capture & pend_clr);
        ram_en    = wr_en || (state == ST_FETCH);
        ram_addr  = wr_en ? event_count[ADDR_W-1:0] : rd_ptr[ADDR_W-1:0];
        ev_time   = rd_data[EV_TIME_LSB +: TIME_W];
        ev_edge   = rd_data[EV_EDGE];
        ev_key    = rd_data[EV_KEY_LSB +: KEY_W];
        rd_ptr_inc = rd_ptr + CNT_ONE;
    end

    event_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .EV_W   (EV_W)
    ) u_ram (
        .clock (clock),
        .en    (ram_en),
        .we    (wr_en),
        .addr  (ram_addr),
        .wdata (wr_data),
        .rdata (rd_data)
    );

    // Per-key capture timestamps and edge polarity carry no reset.
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (capture[k]) begin
                ts[k]    <= sys_time;
                pedge[k] <= keys[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            presc       <= PRESC_RELOAD;
            keys_q      <= '0;
            pending     <= '0;
            stopping    <= 1'b0;
            rd_ptr      <= '0;
            play_keys   <= '0;
            sys_time    <= '0;
            event_count <= '0;
            last_event  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done   <= 1'b0;
            keys_q <= keys;

            if (state != ST_IDLE) begin
                if (presc == '0) begin
                    presc <= PRESC_RELOAD;
                    if (!sat) begin
                        sys_time <= sys_time + TIME_ONE;
                    end
                end else begin
                    presc <= presc - PRESC_ONE;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (mode_e'(mode))
                            MODE_RECORD: begin
                                state       <= ST_REC;
                                busy        <= 1'b1;
                                event_count <= '0;
                                overflow    <= 1'b0;
                                sys_time    <= '0;
                                presc       <= PRESC_RELOAD;
                                pending     <= '0;
                                stopping    <= 1'b0;
                            end
                            MODE_PLAY: begin
                                if (event_count != '0) begin
                                    state    <= ST_FETCH;
                                    busy     <= 1'b1;
                                    rd_ptr   <= '0;
                                    sys_time <= '0;
                                    presc    <= PRESC_RELOAD;
                                end else begin
                                    done <= 1'b1;
                                end
                            end
                            MODE_CLEAR: begin
                                event_count <= '0;
                                overflow    <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_REC: begin
                    if (wr_en) begin
                        event_count <= event_count + CNT_ONE;
                        last_event  <= wr_data;
                    end
                    // A pending entry that cannot be written, a replaced entry, or a dropped edge all lose data.
                    if ((wr_any && full) || collide || drop_edge) begin
                        overflow <= 1'b1;
                    end
                    pending <= pend_clr | capture;
                    if (rec_exit) begin
                        if (pend_clr == '0) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            stopping <= 1'b0;
                        end else begin
                            stopping <= 1'b1;
                        end
                    end
                end

                ST_FETCH: begin
                    if (stop) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        play_keys <= '0;
                        done      <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (stop) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        play_keys <= '0;
                        done      <= 1'b1;
                    end else if (sys_time >= ev_time) begin
                        for (int k = 0; k < NUM_KEYS; k++) begin
                            if (ev_key == KEY_W'(k)) begin
                                play_keys[k] <= ev_edge;
                            end
                        end
                        last_event <= rd_data;
                        rd_ptr     <= rd_ptr_inc;
                        if (rd_ptr_inc == event_count) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            play_keys <= '0;
                            done      <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with TICK_DIV=4, TIME_W=8, DEPTH=8.
module tb_note_recorder;

    localparam int NK = 4;
    localparam int KW = 2;
    localparam int TW = 8;
    localparam int AW = 3;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      mode;
    logic            start;
    logic            stop;
    logic [NK-1:0]   keys;
    logic [NK-1:0]   play_keys;
    logic [TW-1:0]   sys_time;
    logic [AW:0]     event_count;
    logic [KW+TW:0]  last_event;
    logic            busy;
    logic            done;
    logic            overflow;

    int nvec = 0;
    int nerr = 0;
    int done_cnt = 0;
    int prev_cnt = 0;
    logic [KW+TW:0] wr_log [$];

    always #5 clock = ~clock;

    note_recorder #(
        .NUM_KEYS (NK),
        .KEY_W    (KW),
        .TICK_DIV (4),
        .TIME_W   (TW),
        .DEPTH    (8),
        .ADDR_W   (AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mode        (mode),
        .start       (start),
        .stop        (stop),
        .keys        (keys),
        .play_keys   (play_keys),
        .sys_time    (sys_time),
        .event_count (event_count),
        .last_event  (last_event),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    // Logs every written event and counts done pulses.
    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
        if (int'(event_count) == prev_cnt + 1) wr_log.push_back(last_event);
        prev_cnt = int'(event_count);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic wait_time(input int t, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (int'(sys_time) == t) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (20) step();
        nvec++; if (sys_time !== 8'd0) begin nerr++; $display("FAIL reset_sys_time: got %0d expected 0", sys_time); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy); end
        nvec++; if (play_keys !== 4'b0) begin nerr++; $display("FAIL reset_play_keys: got %b expected 0000", play_keys); end
        nvec++; if (event_count !== 4'd0) begin nerr++; $display("FAIL reset_event_count: got %0d expected 0", event_count); end
        nvec++; if (last_event !== 11'd0) begin nerr++; $display("FAIL reset_last_event: got %h expected 0", last_event); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_record();
        bit ok1, ok2, ok3;
        wr_log.delete();
        done_cnt = 0;
        pulse_start(2'b01);
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rec_busy: got %b expected 1", busy); end
        wait_time(3, ok1);
        keys = 4'b0010;
        wait_time(7, ok2);
        keys = 4'b0000;
        repeat (3) step();
        pulse_stop();
        wait_idle(50, ok3);
        repeat (2) step();
        nvec++; if (!(ok1 && ok2 && ok3)) begin nerr++; $display("FAIL rec_timeout: got %b%b%b expected 111", ok1, ok2, ok3); end
        nvec++; if (event_count !== 4'd2) begin nerr++; $display("FAIL rec_count: got %0d expected 2", event_count); end
        nvec++; if (wr_log.size() != 2) begin nerr++; $display("FAIL rec_log_size: got %0d expected 2", wr_log.size()); end
        nvec++; if (wr_log[0] !== {2'd1, 1'b1, 8'd3}) begin nerr++; $display("FAIL rec_ev0: got %h expected %h", wr_log[0], {2'd1, 1'b1, 8'd3}); end
        nvec++; if (wr_log[1] !== {2'd1, 1'b0, 8'd7}) begin nerr++; $display("FAIL rec_ev1: got %h expected %h", wr_log[1], {2'd1, 1'b0, 8'd7}); end
        nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL rec_done_pulses: got %0d expected 1", done_cnt); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL rec_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_play();
        int rise = -1;
        int fall = -1;
        logic prev = 1'b0;
        bit ok = 1'b0;
        done_cnt = 0;
        pulse_start(2'b10);
        for (int i = 0; i < 300; i++) begin
            step();
            if (play_keys[1] && !prev) rise = int'(sys_time);
            if (!play_keys[1] && prev) fall = int'(sys_time);
            prev = play_keys[1];
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) step();
        nvec++; if (!ok) begin nerr++; $display("FAIL play_timeout: got busy %b expected 0", busy); end
        nvec++; if (rise != 3) begin nerr++; $display("FAIL play_rise_tick: got %0d expected 3", rise); end
        nvec++; if (fall != 7) begin nerr++; $display("FAIL play_fall_tick: got %0d expected 7", fall); end
        nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL play_done_pulses: got %0d expected 1", done_cnt); end
        nvec++; if (play_keys !== 4'b0) begin nerr++; $display("FAIL play_end_keys: got %b expected 0000", play_keys); end
        nvec++; if (last_event !== {2'd1, 1'b0, 8'd7}) begin nerr++; $display("FAIL play_last_event: got %h expected %h", last_event, {2'd1, 1'b0, 8'd7}); end
    endtask

    task automatic test_simultaneous();
        bit ok1, ok2;
        wr_log.delete();
        done_cnt = 0;
        pulse_start(2'b01);
        wait_time(5, ok1);
        keys = 4'b0101;
        repeat (4) step();
        pulse_stop();
        wait_idle(50, ok2);
        repeat (2) step();
        keys = 4'b0000;
        step();
        nvec++; if (!(ok1 && ok2)) begin nerr++; $display("FAIL simul_timeout: got %b%b expected 11", ok1, ok2); end
        nvec++; if (event_count !== 4'd2) begin nerr++; $display("FAIL simul_count: got %0d expected 2 (held keys log no release)", event_count); end
        nvec++; if (wr_log[0] !== {2'd0, 1'b1, 8'd5}) begin nerr++; $display("FAIL simul_ev0: got %h expected %h", wr_log[0], {2'd0, 1'b1, 8'd5}); end
        nvec++; if (wr_log[1] !== {2'd2, 1'b1, 8'd5}) begin nerr++; $display("FAIL simul_ev1: got %h expected %h", wr_log[1], {2'd2, 1'b1, 8'd5}); end
        nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL simul_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_overflow();
        logic [TW-1:0] t1 = '0;
        logic [TW-1:0] t8 = '0;
        bit ok;
        wr_log.delete();
        done_cnt = 0;
        pulse_start(2'b01);
        // Nine toggles of key 0, two cycles apart: press, release, ..., press.
        for (int i = 0; i < 9; i++) begin
            keys[0] = ~keys[0];
            if (i == 0) t1 = sys_time;
            if (i == 7) t8 = sys_time;
            step();
            step();
        end
        repeat (2) step();
        pulse_stop();
        wait_idle(50, ok);
        repeat (2) step();
        keys = 4'b0000;
        step();
        nvec++; if (!ok) begin nerr++; $display("FAIL ovf_timeout: got busy %b expected 0", busy); end
        nvec++; if (event_count !== 4'd8) begin nerr++; $display("FAIL ovf_count: got %0d expected 8", event_count); end
        nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        nvec++; if (wr_log.size() != 8) begin nerr++; $display("FAIL ovf_log_size: got %0d expected 8", wr_log.size()); end
        nvec++; if (wr_log[0] !== {2'd0, 1'b1, t1}) begin nerr++; $display("FAIL ovf_ev0: got %h expected %h", wr_log[0], {2'd0, 1'b1, t1}); end
        nvec++; if (wr_log[7] !== {2'd0, 1'b0, t8}) begin nerr++; $display("FAIL ovf_ev7: got %h expected %h", wr_log[7], {2'd0, 1'b0, t8}); end
        nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL ovf_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_clear();
        pulse_start(2'b11);
        nvec++; if (event_count !== 4'd0) begin nerr++; $display("FAIL clear_count: got %0d expected 0", event_count); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL clear_overflow: got %b expected 0", overflow); end
        done_cnt = 0;
        pulse_start(2'b10);
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL empty_play_done: got %b expected 1", done); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL empty_play_busy: got %b expected 0", busy); end
        step();
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL empty_play_done_width: got %b expected 0", done); end
        step();
        nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL empty_play_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_autostop();
        bit ok1, ok2, ok3, ok4;
        wr_log.delete();
        done_cnt = 0;
        pulse_start(2'b01);
        wait_time(2, ok1);
        keys = 4'b1000;
        wait_time(200, ok2);
        keys = 4'b0000;
        wait_idle(1500, ok3);
        repeat (2) step();
        nvec++; if (!(ok1 && ok2 && ok3)) begin nerr++; $display("FAIL auto_timeout: got %b%b%b expected 111", ok1, ok2, ok3); end
        nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL auto_done_pulses: got %0d expected 1", done_cnt); end
        nvec++; if (sys_time !== 8'd255) begin nerr++; $display("FAIL auto_sys_time: got %0d expected 255", sys_time); end
        nvec++; if (event_count !== 4'd2) begin nerr++; $display("FAIL auto_count: got %0d expected 2", event_count); end
        nvec++; if (wr_log[0] !== {2'd3, 1'b1, 8'd2}) begin nerr++; $display("FAIL auto_ev0: got %h expected %h", wr_log[0], {2'd3, 1'b1, 8'd2}); end
        nvec++; if (wr_log[1] !== {2'd3, 1'b0, 8'd200}) begin nerr++; $display("FAIL auto_ev1: got %h expected %h", wr_log[1], {2'd3, 1'b0, 8'd200}); end

        done_cnt = 0;
        pulse_start(2'b10);
        wait_time(6, ok4);
        step();
        nvec++; if (!ok4) begin nerr++; $display("FAIL stop_play_timeout: got sys_time %0d expected 6", sys_time); end
        nvec++; if (play_keys !== 4'b1000) begin nerr++; $display("FAIL stop_play_keys_mid: got %b expected 1000", play_keys); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        nvec++; if (play_keys !== 4'b0000) begin nerr++; $display("FAIL stop_play_keys_cleared: got %b expected 0000", play_keys); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL stop_play_busy: got %b expected 0", busy); end
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL stop_play_done: got %b expected 1", done); end
        repeat (2) step();
        nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL stop_play_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        pulse_start(2'b01);
        keys = 4'b0001;
        repeat (3) step();
        nvec++; if (event_count !== 4'd1) begin nerr++; $display("FAIL mid_pre_count: got %0d expected 1", event_count); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mid_busy: got %b expected 0", busy); end
        nvec++; if (event_count !== 4'd0) begin nerr++; $display("FAIL mid_count: got %0d expected 0", event_count); end
        nvec++; if (sys_time !== 8'd0) begin nerr++; $display("FAIL mid_sys_time: got %0d expected 0", sys_time); end
        nvec++; if (last_event !== 11'd0) begin nerr++; $display("FAIL mid_last_event: got %h expected 0", last_event); end
        keys = 4'b0000;
        step();
    endtask

    initial begin
        reset = 1'b1;
        mode  = 2'b00;
        start = 1'b0;
        stop  = 1'b0;
        keys  = '0;
        test_reset();
        test_record();
        test_play();
        test_simultaneous();
        test_overflow();
        test_clear();
        test_autostop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
